// File: rtl/disp_pkg.sv
// Shared dispatch-path definitions: payload type, issue-queue size and the
// issue-count helper also used by the allocation stage.
package disp_pkg;

  localparam int INS_W    = 32;
  localparam int IQ_DEPTH = 16;

  typedef logic [INS_W-1:0] ins_t;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage

// File: rtl/fifo_2w2r.sv
// Pointer-addressed instruction storage with two write and two read ports.
// Flow control and pointer management live in the owner.
module fifo_2w2r
  import disp_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_1,
  input  logic             we_2,
  input  logic [PTR_W-1:0] wr_addr_1,
  input  logic [PTR_W-1:0] wr_addr_2,
  input  logic [INS_W-1:0] wr_data_1,
  input  logic [INS_W-1:0] wr_data_2,
  input  logic [PTR_W-1:0] rd_addr_1,
  input  logic [PTR_W-1:0] rd_addr_2,
  output logic [INS_W-1:0] rd_data_1,
  output logic [INS_W-1:0] rd_data_2
);

  ins_t mem_q [DEPTH];
  ins_t mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we_1) mem_d[wr_addr_1] = wr_data_1;
    if (we_2) mem_d[wr_addr_2] = wr_data_2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data_1 = mem_q[rd_addr_1];
  assign rd_data_2 = mem_q[rd_addr_2];

endmodule

// File: rtl/dispatch_buffer.sv
// 2-wide in-order staging buffer between decode and issue-queue allocation;
// mirrors issue-queue occupancy so it never dispatches into a full queue.
module dispatch_buffer
  import disp_pkg::*;
#(
  parameter int BUF_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         dec_vld_1,
  input  logic                         dec_vld_2,
  input  logic [INS_W-1:0]             dec_ins_1,
  input  logic [INS_W-1:0]             dec_ins_2,
  output logic                         dec_stall,
  input  logic                         ins_in_1,
  input  logic                         ins_in_2,
  input  logic                         ins_in_3,
  input  logic                         ins_in_4,
  output logic                         ins_new_1_vld,
  output logic                         ins_new_2_vld,
  output logic [INS_W-1:0]             ins_new_1,
  output logic [INS_W-1:0]             ins_new_2,
  output logic [$clog2(BUF_DEPTH):0]   buf_count,
  output logic [$clog2(IQ_DEPTH):0]    iq_count
);

  localparam int PTR_W  = $clog2(BUF_DEPTH);
  localparam int BCNT_W = PTR_W + 1;
  localparam int ICNT_W = $clog2(IQ_DEPTH) + 1;

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [BCNT_W-1:0] buf_count_q, buf_count_d;
  logic [ICNT_W-1:0] iq_count_q, iq_count_d;
  logic [ICNT_W-1:0] iq_free;
  logic [ICNT_W-1:0] iq_after_issue;
  logic [ICNT_W-1:0] issued;
  logic [1:0]        n_disp;
  logic [1:0]        n_acc;

  assign issued = ICNT_W'(popcount4({ins_in_4, ins_in_3, ins_in_2, ins_in_1}));

  always_comb begin
    dec_stall = (BCNT_W'(BUF_DEPTH) - buf_count_q) < BCNT_W'(2);
    iq_free   = ICNT_W'(IQ_DEPTH) - iq_count_q;

    // Same-cycle issues are deliberately not credited; flush suppresses dispatch.
    n_disp = 2'd0;
    if (!flush && buf_count_q != '0 && iq_free != '0) begin
      if (buf_count_q == BCNT_W'(1) || iq_free == ICNT_W'(1)) n_disp = 2'd1;
      else                                                    n_disp = 2'd2;
    end

    n_acc = 2'd0;
    if (!flush && !dec_stall && dec_vld_1) n_acc = dec_vld_2 ? 2'd2 : 2'd1;

    if (flush) begin
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      buf_count_d = '0;
    end else begin
      rd_ptr_d    = rd_ptr_q + PTR_W'(n_disp);
      wr_ptr_d    = wr_ptr_q + PTR_W'(n_acc);
      buf_count_d = buf_count_q + BCNT_W'(n_acc) - BCNT_W'(n_disp);
    end

    iq_after_issue = (issued > iq_count_q) ? '0 : iq_count_q - issued;
    iq_count_d     = iq_after_issue + ICNT_W'(n_disp);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      buf_count_q <= '0;
      iq_count_q  <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      buf_count_q <= buf_count_d;
      iq_count_q  <= iq_count_d;
    end
  end

  fifo_2w2r #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_1      (n_acc != 2'd0),
    .we_2      (n_acc == 2'd2),
    .wr_addr_1 (wr_ptr_q),
    .wr_addr_2 (wr_ptr_q + PTR_W'(1)),
    .wr_data_1 (dec_ins_1),
    .wr_data_2 (dec_ins_2),
    .rd_addr_1 (rd_ptr_q),
    .rd_addr_2 (rd_ptr_q + PTR_W'(1)),
    .rd_data_1 (ins_new_1),
    .rd_data_2 (ins_new_2)
  );

  assign ins_new_1_vld = n_disp != 2'd0;
  assign ins_new_2_vld = n_disp == 2'd2;
  assign buf_count     = buf_count_q;
  assign iq_count      = iq_count_q;

  // Protocol violations from upstream or from the issue side.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(issued > iq_count_q))
        else $error("dispatch_buffer: more issues than tracked iq entries");
      assert (!(dec_vld_2 && !dec_vld_1))
        else $error("dispatch_buffer: dec_vld_2 without dec_vld_1");
    end
  end

endmodule
